// File: rtl/vrf_read_seq_pkg.sv
// vrf_read_seq_pkg: shared state encoding, request/command shapes and default widths
package vrf_read_seq_pkg;

    localparam int VS_BITS_DEF         = 5;
    localparam int GROUP_BITS_DEF      = 4;
    localparam int COUNT_BITS_DEF      = 6;
    localparam int SRC_BITS_DEF        = 4;
    localparam int IDX_BITS_DEF        = 3;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    typedef struct packed {
        logic [VS_BITS_DEF-1:0]    vs;
        logic [GROUP_BITS_DEF-1:0] group_index;
        logic [SRC_BITS_DEF-1:0]   read_source;
        logic [IDX_BITS_DEF-1:0]   instruction_index;
    } read_req_t;

    typedef struct packed {
        logic [VS_BITS_DEF-1:0]    vs;
        logic [COUNT_BITS_DEF-1:0] last_group;
        logic [SRC_BITS_DEF-1:0]   read_source;
        logic [IDX_BITS_DEF-1:0]   instruction_index;
    } read_cmd_t;

endpackage

// File: rtl/vrf_read_credit_counter.sv
// vrf_read_credit_counter: saturating up/down count of reads in flight to the read pipe
module vrf_read_credit_counter #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic has_credit_o,
    output logic is_zero_o,
    output logic next_zero_o
);

    logic [W-1:0] count_q, count_d;

    // Simultaneous issue and return cancel; a return with nothing in flight is dropped
    always_comb begin
        count_d = (inc_i && !dec_i) ? count_q + 1'b1 :
                  (dec_i && !inc_i && count_q != '0) ? count_q - 1'b1 : count_q;
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset) count_q <= '0;
        else count_q <= count_d;
    end

    assign has_credit_o = count_q < W'(MAX_OUTSTANDING);
    assign is_zero_o    = count_q == '0;
    assign next_zero_o  = count_d == '0;

endmodule

// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer: expands one operand read command into per-group read-pipe requests.
// Build option: define VRF_READ_SEQ_KILL_EN to let kill abort issuing in ISSUE.
module vrf_read_sequencer
    import vrf_read_seq_pkg::*;
#(
    parameter int VS_BITS         = VS_BITS_DEF,
    parameter int GROUP_BITS      = GROUP_BITS_DEF,
    parameter int COUNT_BITS      = COUNT_BITS_DEF,
    parameter int SRC_BITS        = SRC_BITS_DEF,
    parameter int IDX_BITS        = IDX_BITS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  cmd_ready,
    input  logic                  cmd_valid,
    input  logic [VS_BITS-1:0]    cmd_bits_vs,
    input  logic [COUNT_BITS-1:0] cmd_bits_lastGroup,
    input  logic [SRC_BITS-1:0]   cmd_bits_readSource,
    input  logic [IDX_BITS-1:0]   cmd_bits_instructionIndex,
    input  logic                  enqueue_ready,
    output logic                  enqueue_valid,
    output logic [VS_BITS-1:0]    enqueue_bits_vs,
    output logic [GROUP_BITS-1:0] enqueue_bits_groupIndex,
    output logic [SRC_BITS-1:0]   enqueue_bits_readSource,
    output logic [IDX_BITS-1:0]   enqueue_bits_instructionIndex,
    input  logic                  dataFire,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [VS_BITS-1:0]    vs_q;
    logic [COUNT_BITS-1:0] last_q;
    logic [SRC_BITS-1:0]   src_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic                  done_q, done_d;
    logic [COUNT_BITS-1:0] reg_step;
    logic                  cmd_fire, enq_fire, has_credit, next_zero, kill_act, unused_is_zero;

`ifdef VRF_READ_SEQ_KILL_EN
    assign kill_act = kill;
`else
    logic unused_kill;
    assign unused_kill = kill;
    assign kill_act    = 1'b0;
`endif

    assign cmd_fire = cmd_ready && cmd_valid;
    assign enq_fire = enqueue_valid && enqueue_ready;
    assign reg_step = count_q >> GROUP_BITS;

    vrf_read_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
        .clock        (clock),
        .reset        (reset),
        .inc_i        (enq_fire),
        .dec_i        (dataFire),
        .has_credit_o (has_credit),
        .is_zero_o    (unused_is_zero),
        .next_zero_o  (next_zero)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Next state: last group fired or kill ends issue; drain waits for every credit back
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = ISSUE;
            ISSUE:   if (kill_act || (enq_fire && count_q == last_q)) state_d = DRAIN;
            DRAIN:   if (next_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs depend only on registered state and kill, never on enqueue_ready
    always_comb begin
        cmd_ready     = state_q == IDLE;
        busy          = state_q != IDLE;
        enqueue_valid = state_q == ISSUE && has_credit && !kill_act;
    end

    // Group counter restarts per command; done fires as the last credit returns
    always_comb begin
        count_d = cmd_fire ? '0 : enq_fire ? count_q + 1'b1 : count_q;
        done_d  = state_q == DRAIN && next_zero;
    end

    // Command latch, group counter and completion pulse registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            vs_q    <= '0;
            last_q  <= '0;
            src_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
            if (cmd_fire) begin
                vs_q   <= cmd_bits_vs;
                last_q <= cmd_bits_lastGroup;
                src_q  <= cmd_bits_readSource;
                idx_q  <= cmd_bits_instructionIndex;
            end
        end
    end

    assign enqueue_bits_vs               = vs_q + VS_BITS'(reg_step);
    assign enqueue_bits_groupIndex       = count_q[GROUP_BITS-1:0];
    assign enqueue_bits_readSource       = src_q;
    assign enqueue_bits_instructionIndex = idx_q;
    assign done                          = done_q;

endmodule
